// File: rtl/hwag_coil_sched.sv
// rtl/hwag_coil_sched.sv - multi-channel ignition coil scheduler driven by the HWAG angle counter
//
// Each channel charges its coil from the set point (fire - dwell, wrapped into
// 0..MAXACR) up to the fire angle. Fire/dwell/enable are double-buffered: host
// writes land in pending registers and all channels commit together at the
// angle wrap, or continuously while the HWAG is not running. A per-channel
// max-dwell watchdog ends a charge that runs too long and latches a fault.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hwag_run        HWAG synchronised; low forces every coil off
//   angle           current angle count 0..MAXACR
//   angle_stb       one-clk pulse when angle has advanced
//   max_dwell_clks  watchdog limit in clk cycles, 0 disables it
//   cfg_we, cfg_ch  pending config write strobe and channel index
//   cfg_ena, cfg_fire, cfg_dwell   pending config values
//   fault_clr       per-channel sticky fault clear
//   coil_out        registered coil drive, high while charging
//   fault           sticky max-dwell fault per channel
module hwag_coil_sched #(
    parameter int NCH    = 4,
    parameter int AW     = 24,
    parameter int MAXACR = 3839,
    parameter int TW     = 24,
    parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hwag_run,
    input  logic [AW-1:0]  angle,
    input  logic           angle_stb,
    input  logic [TW-1:0]  max_dwell_clks,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic           cfg_ena,
    input  logic [AW-1:0]  cfg_fire,
    input  logic [AW-1:0]  cfg_dwell,
    input  logic [NCH-1:0] fault_clr,
    output logic [NCH-1:0] coil_out,
    output logic [NCH-1:0] fault
);

    localparam logic [AW-1:0] MAXA   = AW'(MAXACR);
    localparam logic [AW-1:0] ACYC   = AW'(MAXACR + 1);
    localparam logic [CHW:0]  NCH_L  = (CHW + 1)'(NCH);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_CHARGE = 2'd1,
        ST_HOLD   = 2'd2
    } st_t;

    logic [NCH-1:0] pend_ena;
    logic [AW-1:0]  pend_fire  [NCH];
    logic [AW-1:0]  pend_dwell [NCH];
    logic [NCH-1:0] act_ena;
    logic [AW-1:0]  act_fire   [NCH];
    logic [AW-1:0]  act_dwell  [NCH];

    st_t            state_q [NCH];
    st_t            state_d [NCH];
    logic [TW-1:0]  wd_q    [NCH];
    logic [AW-1:0]  set_pt  [NCH];
    logic [NCH-1:0] at_fire;
    logic [NCH-1:0] at_set;
    logic [NCH-1:0] wd_hit;
    logic [NCH-1:0] expire;

    logic           commit;
    logic           wr_hit;
    logic [AW-1:0]  wr_fire;
    logic [AW-1:0]  wr_dwell;

    always_comb begin
        commit   = (angle_stb && (angle == '0)) || !hwag_run;
        wr_hit   = cfg_we && ({1'b0, cfg_ch} < NCH_L);
        wr_fire  = (cfg_fire  > MAXA) ? MAXA : cfg_fire;
        wr_dwell = (cfg_dwell > MAXA) ? MAXA : cfg_dwell;
    end

    // Commit reads the pending value from before this clock, so a write that
    // coincides with the commit only lands in pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_ena <= '0;
            act_ena  <= '0;
            for (int i = 0; i < NCH; i++) begin
                pend_fire[i]  <= '0;
                pend_dwell[i] <= '0;
                act_fire[i]   <= '0;
                act_dwell[i]  <= '0;
            end
        end else begin
            if (commit) begin
                act_ena   <= pend_ena;
                act_fire  <= pend_fire;
                act_dwell <= pend_dwell;
            end
            if (wr_hit) begin
                pend_ena[cfg_ch]   <= cfg_ena;
                pend_fire[cfg_ch]  <= wr_fire;
                pend_dwell[cfg_ch] <= wr_dwell;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            set_pt[i]  = (act_dwell[i] <= act_fire[i]) ? (act_fire[i] - act_dwell[i])
                                                       : (act_fire[i] + ACYC - act_dwell[i]);
            at_fire[i] = angle_stb && (angle == act_fire[i]);
            // dwell==0 puts the set point on the fire point; such a channel never charges.
            at_set[i]  = angle_stb && (angle == set_pt[i]) && act_ena[i] && (act_dwell[i] != '0);
            wd_hit[i]  = (state_q[i] == ST_CHARGE) && (max_dwell_clks != '0)
                         && (wd_q[i] == max_dwell_clks - TW'(1));
            expire[i]  = wd_hit[i] && hwag_run;
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (at_set[i]) state_d[i] = ST_CHARGE;
                end
                ST_CHARGE: begin
                    // A fire match wins over a same-clock watchdog expiry; the
                    // fault is still latched from expire.
                    if (at_fire[i])                    state_d[i] = ST_OFF;
                    else if (wd_hit[i])                state_d[i] = ST_HOLD;
                    else if (commit && !pend_ena[i])   state_d[i] = ST_OFF;
                end
                ST_HOLD: begin
                    if (at_fire[i]) state_d[i] = ST_OFF;
                end
                default: state_d[i] = ST_OFF;
            endcase
            if (!hwag_run) state_d[i] = ST_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coil_out <= '0;
            fault    <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_OFF;
                wd_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                coil_out[i] <= (state_d[i] == ST_CHARGE);
                // Cleared on entry to CHARGE and whenever not charging; saturates.
                if ((state_q[i] != ST_CHARGE) || (state_d[i] != ST_CHARGE))
                    wd_q[i] <= '0;
                else if (wd_q[i] != '1)
                    wd_q[i] <= wd_q[i] + TW'(1);
                fault[i] <= (fault[i] && !fault_clr[i]) || expire[i];
            end
        end
    end

endmodule

// File: tb/tb_hwag_coil_sched.sv
// tb/tb_hwag_coil_sched.sv - self-checking bench for hwag_coil_sched
module tb_hwag_coil_sched;

    localparam int NCH    = 5;
    localparam int AW     = 24;
    localparam int MAXACR = 3839;
    localparam int TW     = 24;
    localparam int CHW    = 3;
    localparam int ACYC   = MAXACR + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hwag_run = 1'b0;
    logic [AW-1:0]  angle = '0;
    logic           angle_stb = 1'b0;
    logic [TW-1:0]  max_dwell_clks = '0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic           cfg_ena = 1'b0;
    logic [AW-1:0]  cfg_fire = '0;
    logic [AW-1:0]  cfg_dwell = '0;
    logic [NCH-1:0] fault_clr = '0;
    logic [NCH-1:0] coil_out;
    logic [NCH-1:0] fault;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: pending/active config, charge windows, fault latches
    bit           mp_ena   [NCH];
    int           mp_fire  [NCH];
    int           mp_dwell [NCH];
    bit           ma_ena   [NCH];
    int           ma_fire  [NCH];
    int           ma_dwell [NCH];
    bit           m_on     [NCH];
    bit           m_hold   [NCH];
    int           m_rise   [NCH];
    bit [NCH-1:0] m_fault;

    always #5 clk = ~clk;

    hwag_coil_sched #(.NCH(NCH), .AW(AW), .MAXACR(MAXACR), .TW(TW)) dut (
        .clk(clk), .rst(rst), .hwag_run(hwag_run), .angle(angle), .angle_stb(angle_stb),
        .max_dwell_clks(max_dwell_clks), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ena(cfg_ena),
        .cfg_fire(cfg_fire), .cfg_dwell(cfg_dwell), .fault_clr(fault_clr),
        .coil_out(coil_out), .fault(fault)
    );

    function automatic bit [NCH-1:0] exp_coil();
        bit [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_on[i];
        return v;
    endfunction

    // Predict the state after the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit commit;
        bit ex;
        int set_a;
        cyc++;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                mp_ena[i] = 0; mp_fire[i] = 0; mp_dwell[i] = 0;
                ma_ena[i] = 0; ma_fire[i] = 0; ma_dwell[i] = 0;
                m_on[i] = 0; m_hold[i] = 0; m_rise[i] = 0;
            end
            m_fault = '0;
            return;
        end
        commit = (angle_stb && angle == 0) || !hwag_run;
        for (int i = 0; i < NCH; i++) begin
            set_a = (ma_fire[i] - ma_dwell[i] + ACYC) % ACYC;
            ex = m_on[i] && hwag_run && (max_dwell_clks != 0)
                 && ((cyc - m_rise[i]) == int'(max_dwell_clks));
            if (!hwag_run) begin
                m_on[i] = 0; m_hold[i] = 0;
            end else if (m_on[i]) begin
                if (angle_stb && angle == ma_fire[i]) m_on[i] = 0;
                else if (ex) begin m_on[i] = 0; m_hold[i] = 1; end
                else if (commit && !mp_ena[i]) m_on[i] = 0;
            end else if (m_hold[i]) begin
                if (angle_stb && angle == ma_fire[i]) m_hold[i] = 0;
            end else if (angle_stb && ma_ena[i] && ma_dwell[i] != 0 && angle == set_a) begin
                m_on[i] = 1; m_rise[i] = cyc;
            end
            m_fault[i] = (m_fault[i] && !fault_clr[i]) || ex;
        end
        if (commit)
            for (int i = 0; i < NCH; i++) begin
                ma_ena[i] = mp_ena[i]; ma_fire[i] = mp_fire[i]; ma_dwell[i] = mp_dwell[i];
            end
        if (cfg_we && cfg_ch < NCH) begin
            mp_ena[cfg_ch]   = cfg_ena;
            mp_fire[cfg_ch]  = (cfg_fire  > MAXACR) ? MAXACR : int'(cfg_fire);
            mp_dwell[cfg_ch] = (cfg_dwell > MAXACR) ? MAXACR : int'(cfg_dwell);
        end
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_step(input int a, input int gap);
        angle_stb = 1'b0;
        repeat (gap) adv();
        angle = AW'(a);
        angle_stb = 1'b1;
        adv();
        angle_stb = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input bit ena, input int fire, input int dwell);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_ena = ena;
        cfg_fire = AW'(fire); cfg_dwell = AW'(dwell);
        adv();
        cfg_we = 1'b0;
    endtask

    task automatic commit_by_run();
        hwag_run = 1'b0;
        adv();
        hwag_run = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hwag_run = 1'b0;
        adv(); adv();
        total++; if (coil_out !== 5'b0) begin bad++; $display("FAIL reset_coil got=%b want=00000", coil_out); end
        total++; if (fault !== 5'b0) begin bad++; $display("FAIL reset_fault got=%b want=00000", fault); end
        rst = 1'b0; hwag_run = 1'b1;
        adv();
    endtask

    task automatic test_sweep();
        int rise0 = -1, fall0 = -1, hi1 = 0, a;
        bit prev0 = 0;
        max_dwell_clks = '0;
        write_cfg(0, 1, 1000, 200);
        write_cfg(1, 1, 100, 300);
        commit_by_run();
        for (int k = 0; k < ACYC + 150; k++) begin
            a = k % ACYC;
            strobe_step(a, $urandom_range(0, 1));
            total++;
            if (coil_out !== exp_coil() || fault !== m_fault) begin
                bad++;
                $display("FAIL sweep_model angle=%0d coil=%b want=%b fault=%b want=%b", a, coil_out, exp_coil(), fault, m_fault);
            end
            if (!prev0 && coil_out[0] && rise0 < 0) rise0 = a;
            if (prev0 && !coil_out[0] && fall0 < 0) fall0 = a;
            prev0 = coil_out[0];
            hi1 += int'(coil_out[1]);
        end
        total++; if (rise0 !== 800) begin bad++; $display("FAIL sweep_rise0 got=%0d want=800", rise0); end
        total++; if (fall0 !== 1000) begin bad++; $display("FAIL sweep_fall0 got=%0d want=1000", fall0); end
        total++; if (hi1 !== 300) begin bad++; $display("FAIL wrap_len1 got=%0d want=300", hi1); end
    endtask

    task automatic test_watchdog();
        int rise_c = -1, fall_c = -1, rise_a = -1, late_hi = 0;
        bit prev = 0;
        write_cfg(0, 0, 1000, 200);
        write_cfg(1, 0, 100, 300);
        write_cfg(2, 1, 500, 100);
        max_dwell_clks = TW'(50);
        commit_by_run();
        for (int a = 0; a <= 600; a++) begin
            for (int g = 0; g < 4; g++) begin
                angle = AW'(a);
                angle_stb = (g == 3);
                adv();
                angle_stb = 1'b0;
                total++;
                if (coil_out !== exp_coil() || fault !== m_fault) begin
                    bad++;
                    $display("FAIL wd_model angle=%0d coil=%b want=%b fault=%b want=%b", a, coil_out, exp_coil(), fault, m_fault);
                end
                if (!prev && coil_out[2] && rise_c < 0) begin rise_c = cyc; rise_a = a; end
                if (prev && !coil_out[2] && fall_c < 0) fall_c = cyc;
                if (fall_c >= 0 && coil_out[2]) late_hi++;
                prev = coil_out[2];
            end
        end
        total++; if (rise_a !== 400) begin bad++; $display("FAIL wd_rise_angle got=%0d want=400", rise_a); end
        total++; if (fall_c - rise_c !== 50) begin bad++; $display("FAIL wd_on_clks got=%0d want=50", fall_c - rise_c); end
        total++; if (fault[2] !== 1'b1) begin bad++; $display("FAIL wd_fault got=%b want=1", fault[2]); end
        total++; if (late_hi !== 0) begin bad++; $display("FAIL wd_recharge got=%0d want=0", late_hi); end
    endtask

    task automatic test_midwrite();
        int rise [2] = '{-1, -1};
        int fall [2] = '{-1, -1};
        int a, c;
        bit prev = 0;
        max_dwell_clks = '0;
        write_cfg(2, 0, 500, 100);
        write_cfg(0, 1, 1000, 200);
        commit_by_run();
        for (int k = 0; k < ACYC + 2100; k++) begin
            a = k % ACYC;
            c = k / ACYC;
            if (k == 1500) begin
                cfg_we = 1'b1; cfg_ch = 3'd0; cfg_ena = 1'b1; cfg_fire = 24'd2000; cfg_dwell = 24'd200;
            end
            strobe_step(a, $urandom_range(0, 1));
            cfg_we = 1'b0;
            total++;
            if (coil_out !== exp_coil() || fault !== m_fault) begin
                bad++;
                $display("FAIL mid_model angle=%0d coil=%b want=%b", a, coil_out, exp_coil());
            end
            if (!prev && coil_out[0] && rise[c] < 0) rise[c] = a;
            if (prev && !coil_out[0] && fall[c] < 0) fall[c] = a;
            prev = coil_out[0];
        end
        total++; if (rise[0] !== 800)  begin bad++; $display("FAIL mid_rise_old got=%0d want=800", rise[0]); end
        total++; if (fall[0] !== 1000) begin bad++; $display("FAIL mid_fall_old got=%0d want=1000", fall[0]); end
        total++; if (rise[1] !== 1800) begin bad++; $display("FAIL mid_rise_new got=%0d want=1800", rise[1]); end
        total++; if (fall[1] !== 2000) begin bad++; $display("FAIL mid_fall_new got=%0d want=2000", fall[1]); end
    endtask

    task automatic test_run_drop();
        bit [NCH-1:0] fb;
        int hi0 = 0;
        write_cfg(0, 1, 1000, 200);
        commit_by_run();
        for (int a = 0; a <= 900; a++) strobe_step(a, $urandom_range(0, 1));
        total++; if (coil_out[0] !== 1'b1) begin bad++; $display("FAIL drop_precharge got=%b want=1", coil_out[0]); end
        fb = fault;
        hwag_run = 1'b0;
        adv();
        total++; if (coil_out !== 5'b0) begin bad++; $display("FAIL drop_coil got=%b want=00000", coil_out); end
        total++; if (fault !== fb || fault !== m_fault) begin bad++; $display("FAIL drop_fault got=%b want=%b", fault, m_fault); end
        hwag_run = 1'b1;
        for (int a = 901; a <= 1100; a++) begin
            strobe_step(a, $urandom_range(0, 1));
            hi0 += int'(coil_out[0]);
        end
        total++; if (hi0 !== 0) begin bad++; $display("FAIL restart_charge got=%0d want=0", hi0); end
        for (int a = 790; a <= 900; a++) strobe_step(a, 0);
        total++; if (coil_out !== exp_coil()) begin bad++; $display("FAIL restart_model got=%b want=%b", coil_out, exp_coil()); end
        rst = 1'b1;
        adv();
        total++; if (coil_out !== 5'b0 || fault !== 5'b0) begin bad++; $display("FAIL rst_mid got coil=%b fault=%b want=0", coil_out, fault); end
        rst = 1'b0;
        adv();
    endtask

    task automatic test_edge();
        int hi3 = 0, hi_oth = 0, rise4 = -1;
        max_dwell_clks = TW'(5);
        write_cfg(3, 1, 300, 0);
        write_cfg(7, 1, 300, 50);
        write_cfg(2, 1, 500, 100);
        write_cfg(4, 1, 5000, 5000);
        commit_by_run();
        for (int a = 0; a <= 700; a++) begin
            fault_clr = '0;
            fault_clr[2] = coil_out[2];
            strobe_step(a, 0);
            total++;
            if (coil_out !== exp_coil() || fault !== m_fault) begin
                bad++;
                $display("FAIL edge_model angle=%0d coil=%b want=%b fault=%b want=%b", a, coil_out, exp_coil(), fault, m_fault);
            end
            hi3 += int'(coil_out[3]);
            hi_oth += int'(coil_out[0]) + int'(coil_out[1]);
            if (coil_out[4] && rise4 < 0) rise4 = a;
        end
        fault_clr = '0;
        total++; if (hi3 !== 0) begin bad++; $display("FAIL dwell0_active got=%0d want=0", hi3); end
        total++; if (hi_oth !== 0) begin bad++; $display("FAIL badch_write got=%0d want=0", hi_oth); end
        total++; if (rise4 !== 0) begin bad++; $display("FAIL clamp_rise got=%0d want=0", rise4); end
        total++; if (fault[2] !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%b want=1", fault[2]); end
        fault_clr = 5'b00100;
        adv();
        fault_clr = '0;
        total++; if (fault[2] !== 1'b0 || fault[4] !== 1'b1) begin bad++; $display("FAIL fault_clr got=%b want=1 on ch4 only", fault); end
    endtask

    task automatic test_random();
        int a;
        for (int ch = 0; ch < NCH; ch++)
            write_cfg(ch, $urandom_range(0, 3) != 0, $urandom_range(0, 4095), $urandom_range(0, 4095));
        max_dwell_clks = $urandom_range(0, 1) ? TW'($urandom_range(1, 2000)) : '0;
        commit_by_run();
        for (int k = 0; k < 2 * ACYC; k++) begin
            a = k % ACYC;
            if ($urandom_range(0, 399) == 0) begin
                cfg_we = 1'b1; cfg_ch = CHW'($urandom_range(0, 7)); cfg_ena = $urandom_range(0, 3) != 0;
                cfg_fire = AW'($urandom_range(0, 4095)); cfg_dwell = AW'($urandom_range(0, 4095));
            end
            fault_clr = ($urandom_range(0, 63) == 0) ? NCH'($urandom) : '0;
            strobe_step(a, $urandom_range(0, 1));
            cfg_we = 1'b0;
            fault_clr = '0;
            total++;
            if (coil_out !== exp_coil() || fault !== m_fault) begin
                bad++;
                $display("FAIL rand_model angle=%0d coil=%b want=%b fault=%b want=%b", a, coil_out, exp_coil(), fault, m_fault);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sweep();
        test_watchdog();
        test_midwrite();
        test_run_drop();
        test_edge();
        test_random();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
